// File: rtl/i2s_capture_ctrl_pkg.sv
// Shared types and defaults for the I2S capture controller.
package i2s_capture_ctrl_pkg;

    localparam int CAP_DATA_W = 24;
    localparam int CAP_DEPTH  = 1024;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_e;

endpackage

// File: rtl/i2s_capture_ctrl_sample_ram.sv
// Simple dual-port sample RAM: synchronous write, registered read (block RAM style).
module cap_sample_ram #(
    parameter int WIDTH  = 48,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Output register reset maps onto the block RAM output-latch reset.
    always_ff @(posedge clk) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/i2s_capture_ctrl.sv
// Armed/triggered capture of stereo samples into RAM with readout port.
// Optional I2S_CAPTURE_DECIM_EN adds decim_i: store every (decim_i+1)th strobe.
module i2s_capture_ctrl
    import i2s_capture_ctrl_pkg::*;
#(
    parameter int DATA_W = CAP_DATA_W,
    parameter int DEPTH  = CAP_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sample_stb_i,
    input  logic [DATA_W-1:0]     left_i,
    input  logic [DATA_W-1:0]     right_i,
    input  logic                  arm_i,
    input  logic                  abort_i,
    input  logic [ADDR_W:0]       len_i,
    input  logic                  trig_mode_i,
    input  logic [DATA_W-2:0]     trig_level_i,
`ifdef I2S_CAPTURE_DECIM_EN
    input  logic [3:0]            decim_i,
`endif
    input  logic                  rd_req_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [2*DATA_W-1:0]   rd_data_o,
    output logic                  rd_valid_o,
    output logic                  rd_err_o,
    output logic [1:0]            state_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  trig_o,
    output logic [ADDR_W:0]       frame_cnt_o
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

    cap_state_e        state;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_eff;
    logic [ADDR_W:0]   frame_cnt;
    logic              mode_q;
    logic [DATA_W-2:0] level_q;
    logic              trig_hit;
    logic              keep;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_en;
    logic              in_busy;

    // Magnitude with the most negative code saturating to the largest positive one.
    function automatic logic [DATA_W-2:0] mag(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] neg;
        neg = -s;
        if (!s[DATA_W-1])  return s[DATA_W-2:0];
        if (neg[DATA_W-1]) return '1;
        return neg[DATA_W-2:0];
    endfunction

`ifdef I2S_CAPTURE_DECIM_EN
    logic [3:0] dcnt;
    assign keep = (dcnt == decim_i);
`else
    assign keep = 1'b1;
`endif

    assign len_eff  = (len_i == '0 || len_i > DEPTH_L) ? DEPTH_L : len_i;
    assign trig_hit = !mode_q || (mag(left_i) >= level_q) || (mag(right_i) >= level_q);
    assign in_busy  = (state == ST_ARMED) || (state == ST_CAPTURE);
    assign rd_en    = rd_req_i && !in_busy && !rst_i;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        if (!rst_i && !abort_i && sample_stb_i) begin
            if (state == ST_ARMED && trig_hit) begin
                wr_en = 1'b1;
            end else if (state == ST_CAPTURE && frame_cnt != len_q && keep) begin
                wr_en   = 1'b1;
                wr_addr = frame_cnt[ADDR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            mode_q     <= 1'b0;
            level_q    <= '0;
            frame_cnt  <= '0;
            trig_o     <= 1'b0;
            rd_valid_o <= 1'b0;
            rd_err_o   <= 1'b0;
`ifdef I2S_CAPTURE_DECIM_EN
            dcnt       <= '0;
`endif
        end else begin
            trig_o     <= 1'b0;
            rd_valid_o <= rd_en;
            rd_err_o   <= rd_req_i && in_busy;
            if (abort_i) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (arm_i) begin
                            state     <= ST_ARMED;
                            len_q     <= len_eff;
                            mode_q    <= trig_mode_i;
                            level_q   <= trig_level_i;
                            frame_cnt <= '0;
                        end
                    end
                    ST_ARMED: begin
                        if (sample_stb_i && trig_hit) begin
                            state     <= ST_CAPTURE;
                            frame_cnt <= ONE_L;
                            trig_o    <= 1'b1;
`ifdef I2S_CAPTURE_DECIM_EN
                            dcnt      <= '0;
`endif
                        end
                    end
                    ST_CAPTURE: begin
                        if (frame_cnt == len_q) begin
                            state <= ST_DONE;
                        end else if (sample_stb_i) begin
                            if (wr_en) frame_cnt <= frame_cnt + ONE_L;
`ifdef I2S_CAPTURE_DECIM_EN
                            dcnt <= keep ? 4'd0 : dcnt + 4'd1;
`endif
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign state_o     = state;
    assign busy_o      = in_busy;
    assign done_o      = (state == ST_DONE);
    assign frame_cnt_o = frame_cnt;

    cap_sample_ram #(
        .WIDTH  (2*DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk_i),
        .rst     (rst_i),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data ({left_i, right_i}),
        .rd_en   (rd_en),
        .rd_addr (rd_addr_i),
        .rd_data (rd_data_o)
    );

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// Directed bench for i2s_capture_ctrl; covers the decimation path when I2S_CAPTURE_DECIM_EN is set.
module tb_i2s_capture_ctrl;

    logic        clk;
    logic        rst;
    logic        stb;
    logic [23:0] left;
    logic [23:0] right;
    logic        arm;
    logic        abort;
    logic [10:0] len;
    logic        mode;
    logic [22:0] level;
    logic        rd_req;
    logic [9:0]  rd_addr;
    logic [47:0] rd_data;
    logic        rd_valid;
    logic        rd_err;
    logic [1:0]  state;
    logic        busy;
    logic        done;
    logic        trig;
    logic [10:0] fcnt;
`ifdef I2S_CAPTURE_DECIM_EN
    logic [3:0]  decim;
`endif

    int passed = 0;
    int total  = 0;

    i2s_capture_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .sample_stb_i (stb),
        .left_i       (left),
        .right_i      (right),
        .arm_i        (arm),
        .abort_i      (abort),
        .len_i        (len),
        .trig_mode_i  (mode),
        .trig_level_i (level),
`ifdef I2S_CAPTURE_DECIM_EN
        .decim_i      (decim),
`endif
        .rd_req_i     (rd_req),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .rd_valid_o   (rd_valid),
        .rd_err_o     (rd_err),
        .state_o      (state),
        .busy_o       (busy),
        .done_o       (done),
        .trig_o       (trig),
        .frame_cnt_o  (fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one strobe cycle; caller checks, then calls tick() for the idle gap.
    task automatic strobe(input logic [23:0] l, input logic [23:0] r);
        stb   = 1'b1;
        left  = l;
        right = r;
        tick();
        stb   = 1'b0;
    endtask

    task automatic do_arm(input logic [10:0] l, input logic m, input logic [22:0] lv);
        len   = l;
        mode  = m;
        level = lv;
        arm   = 1'b1;
        tick();
        arm   = 1'b0;
    endtask

    task automatic read1(input logic [9:0] a, input logic [47:0] exp, input string tag);
        rd_req  = 1'b1;
        rd_addr = a;
        tick();
        rd_req  = 1'b0;
        check({tag, "_valid"}, 64'(rd_valid), 64'd1);
        check({tag, "_data"}, 64'(rd_data), 64'(exp));
    endtask

    initial begin
        logic [47:0] exp48;
        rst = 1'b1; stb = 1'b0; left = '0; right = '0; arm = 1'b0; abort = 1'b0;
        len = '0; mode = 1'b0; level = '0; rd_req = 1'b0; rd_addr = '0;
`ifdef I2S_CAPTURE_DECIM_EN
        decim = '0;
`endif
        tick(); tick(); tick();
        check("rst_state", 64'(state), 64'd0);
        check("rst_fcnt", 64'(fcnt), 64'd0);
        check("rst_rdata", 64'(rd_data), 64'd0);
        check("rst_pulses", 64'({rd_valid, rd_err, trig, busy, done}), 64'd0);
        rst = 1'b0;
        tick();

        // Immediate trigger, len 4
        do_arm(11'd4, 1'b0, 23'd0);
        check("imm_armed", 64'(state), 64'd1);
        check("imm_busy", 64'(busy), 64'd1);
        for (int n = 0; n < 6; n++) begin
            strobe(24'(32'h10 + n), 24'(32'h100000 + n));
            if (n == 0) begin
                check("imm_trig", 64'(trig), 64'd1);
                check("imm_cap", 64'(state), 64'd2);
                check("imm_fcnt1", 64'(fcnt), 64'd1);
            end
            if (n == 3) begin
                check("imm_fcnt4", 64'(fcnt), 64'd4);
                check("imm_still_cap", 64'(state), 64'd2);
            end
            tick();
            if (n == 3) begin
                check("imm_done", 64'(state), 64'd3);
                check("imm_done_o", 64'(done), 64'd1);
            end
        end
        check("imm_fcnt_final", 64'(fcnt), 64'd4);
        rd_req = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd_addr = 10'(a);
            tick();
            exp48 = {24'(32'h10 + a), 24'(32'h100000 + a)};
            check("imm_rd_valid", 64'(rd_valid), 64'd1);
            check("imm_rd_data", 64'(rd_data), 64'(exp48));
        end
        rd_req = 1'b0;
        tick();
        check("imm_rd_valid_low", 64'(rd_valid), 64'd0);

        // Level trigger with negative right sample
        do_arm(11'd1, 1'b1, 23'h001000);
        strobe(24'h000800, 24'h000000);
        check("lvl_no_trig1", 64'(state), 64'd1);
        check("lvl_trig_low", 64'(trig), 64'd0);
        tick();
        strobe(24'h000FFF, 24'h000000);
        check("lvl_no_trig2", 64'(state), 64'd1);
        tick();
        strobe(24'h000FFF, 24'hFFF000);
        check("lvl_trig", 64'(trig), 64'd1);
        check("lvl_cap", 64'(state), 64'd2);
        tick();
        check("lvl_trig_once", 64'(trig), 64'd0);
        check("lvl_len1_done", 64'(state), 64'd3);
        read1(10'd0, 48'h000FFF_FFF000, "lvl_rd0");

        // Saturated magnitude
        do_arm(11'd1, 1'b1, 23'h7FFFFF);
        strobe(24'h7FFFFE, 24'h000000);
        check("sat_no_trig", 64'(state), 64'd1);
        tick();
        strobe(24'h800000, 24'h000000);
        check("sat_trig", 64'(trig), 64'd1);
        tick();

        // Arm with simultaneous strobe, readout while busy, abort beating arm
        len = 11'd8; mode = 1'b0; level = '0;
        arm = 1'b1; stb = 1'b1; left = 24'h0000AA; right = 24'h0000BB;
        tick();
        arm = 1'b0; stb = 1'b0;
        check("armstb_state", 64'(state), 64'd1);
        check("armstb_fcnt", 64'(fcnt), 64'd0);
        rd_req = 1'b1; rd_addr = '0;
        tick();
        rd_req = 1'b0;
        check("busy_rd_err", 64'(rd_err), 64'd1);
        check("busy_rd_valid", 64'(rd_valid), 64'd0);
        tick();
        check("busy_rd_err_pulse", 64'(rd_err), 64'd0);
        for (int n = 0; n < 5; n++) begin
            strobe(24'(32'h20 + n), 24'(32'h200000 + n));
            tick();
        end
        check("abort_pre_fcnt", 64'(fcnt), 64'd5);
        abort = 1'b1; arm = 1'b1;
        tick();
        abort = 1'b0; arm = 1'b0;
        check("abort_state", 64'(state), 64'd0);
        check("abort_fcnt", 64'(fcnt), 64'd5);
        read1(10'd4, 48'h000024_200004, "abort_rd4");

        // Reset mid-capture
        do_arm(11'd8, 1'b0, 23'd0);
        strobe(24'h1, 24'h2);
        tick();
        strobe(24'h3, 24'h4);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_state", 64'(state), 64'd0);
        check("midrst_fcnt", 64'(fcnt), 64'd0);

        // len 0 means full depth
        do_arm(11'd0, 1'b0, 23'd0);
        for (int n = 0; n < 1024; n++) begin
            strobe(24'(n), 24'(32'h800000 + n));
            if (n == 1022) check("full_not_done", 64'(state), 64'd2);
            tick();
        end
        check("full_state", 64'(state), 64'd3);
        check("full_fcnt", 64'(fcnt), 64'd1024);
        read1(10'd1023, 48'h0003FF_8003FF, "full_rd1023");
        read1(10'd0, 48'h000000_800000, "full_rd0");

`ifdef I2S_CAPTURE_DECIM_EN
        decim = 4'd2;
        do_arm(11'd3, 1'b0, 23'd0);
        for (int n = 0; n < 9; n++) begin
            strobe(24'(32'h30 + n), 24'(n));
            tick();
        end
        check("dec_state", 64'(state), 64'd3);
        check("dec_fcnt", 64'(fcnt), 64'd3);
        read1(10'd0, 48'h000030_000000, "dec_rd0");
        read1(10'd1, 48'h000033_000003, "dec_rd1");
        read1(10'd2, 48'h000036_000006, "dec_rd2");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
